bus_master_arbiter: RTL and testbench

BUS_MASTER_ARBITER -- requirements
Module: bus_master_arbiter

---
 rtl/bus_master_arbiter_if.sv | 40 ++++
 rtl/bus_master_arbiter.sv | 95 +++++++++
 tb/tb_bus_master_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_arbiter_if.sv
// Purpose : bundles the four master request/address channels and the shared
//           slave-side bus driven by bus_master_arbiter.
// Modports: master = view of a requesting agent (drives req_/addr/as_/rw/wr_data,
//           observes grant and the shared bus); slave = view of the arbiter,
//           which receives the requests and drives grants plus the shared bus.
interface bus_master_arbiter_if;
  // Master 0..3 request channels (req_, as_, grnt_ are active-low).
  logic        m0_req_, m1_req_, m2_req_, m3_req_;
  logic        m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [29:0] m0_addr, m1_addr, m2_addr, m3_addr;
  logic        m0_as_, m1_as_, m2_as_, m3_as_;
  logic        m0_rw, m1_rw, m2_rw, m3_rw;
  logic [31:0] m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data;

  // Shared slave side, muxed from the current owner.
  logic [29:0] s_addr;
  logic        s_as_;
  logic        s_rw;
  logic [31:0] s_wr_data;

  modport master (
    output m0_req_, m1_req_, m2_req_, m3_req_,
    output m0_addr, m1_addr, m2_addr, m3_addr,
    output m0_as_, m1_as_, m2_as_, m3_as_,
    output m0_rw, m1_rw, m2_rw, m3_rw,
    output m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    input  m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    input  s_addr, s_as_, s_rw, s_wr_data
  );

  modport slave (
    input  m0_req_, m1_req_, m2_req_, m3_req_,
    input  m0_addr, m1_addr, m2_addr, m3_addr,
    input  m0_as_, m1_as_, m2_as_, m3_as_,
    input  m0_rw, m1_rw, m2_rw, m3_rw,
    input  m0_wr_data, m1_wr_data, m2_wr_data, m3_wr_data,
    output m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_,
    output s_addr, s_as_, s_rw, s_wr_data
  );
endinterface

// File: rtl/bus_master_arbiter.sv
// Purpose : four-master bus arbiter; one registered owner, grants decoded from it,
//           shared slave bus muxed combinationally from the owner's inputs.
// Latency : one cycle from a request sampled with the bus free to its grant.
// Backpressure: the owner keeps the bus while its req_ is low; waiters hold with
//           grant high and are not remembered if they drop req_ before grant.
// Ports   : clk, reset (async, active-high), bus (bus_master_arbiter_if.slave).
// Config  : define BUS_ARB_ROUND_ROBIN_EN for round-robin selection starting
//           after the current owner; undefined gives fixed priority m0>m1>m2>m3.
module bus_master_arbiter (
  input  logic                  clk,
  input  logic                  reset,
  bus_master_arbiter_if.slave   bus
);

  logic [1:0] owner_q;
  logic [1:0] owner_d;
  logic [3:0] req;       // active-high view of the request lines
  logic [1:0] sel;       // candidate owner when the current owner lets go

  assign req = ~{bus.m3_req_, bus.m2_req_, bus.m1_req_, bus.m0_req_};

`ifdef BUS_ARB_ROUND_ROBIN_EN
  // Search owner+1, owner+2, owner+3, owner; first requester wins.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    sel   = owner_q;
    found = 1'b0;
    idx   = owner_q;
    for (int k = 1; k <= 4; k++) begin
      idx = owner_q + 2'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end
`else
  // Lowest-index requester wins.
  always_comb begin
    sel = owner_q;
    if (req[0])      sel = 2'd0;
    else if (req[1]) sel = 2'd1;
    else if (req[2]) sel = 2'd2;
    else if (req[3]) sel = 2'd3;
  end
`endif

  // Owner holds while requesting; parks when nobody requests.
  always_comb begin
    owner_d = owner_q;
    if (!req[owner_q] && (|req)) owner_d = sel;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) owner_q <= 2'd0;
    else       owner_q <= owner_d;
  end

  // Exactly one grant is low at any time, straight from the owner register.
  assign bus.m0_grnt_ = (owner_q != 2'd0);
  assign bus.m1_grnt_ = (owner_q != 2'd1);
  assign bus.m2_grnt_ = (owner_q != 2'd2);
  assign bus.m3_grnt_ = (owner_q != 2'd3);

  // Shared bus follows the owner regardless of whether it is requesting.
  always_comb begin
    bus.s_addr    = bus.m0_addr;
    bus.s_as_     = bus.m0_as_;
    bus.s_rw      = bus.m0_rw;
    bus.s_wr_data = bus.m0_wr_data;
    case (owner_q)
      2'd1: begin
        bus.s_addr    = bus.m1_addr;
        bus.s_as_     = bus.m1_as_;
        bus.s_rw      = bus.m1_rw;
        bus.s_wr_data = bus.m1_wr_data;
      end
      2'd2: begin
        bus.s_addr    = bus.m2_addr;
        bus.s_as_     = bus.m2_as_;
        bus.s_rw      = bus.m2_rw;
        bus.s_wr_data = bus.m2_wr_data;
      end
      2'd3: begin
        bus.s_addr    = bus.m3_addr;
        bus.s_as_     = bus.m3_as_;
        bus.s_rw      = bus.m3_rw;
        bus.s_wr_data = bus.m3_wr_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Purpose : self-checking bench for bus_master_arbiter: directed scenarios then
//           randomized requests/data/reset pulses against a behavioural owner model.
// Ports   : none; instantiates bus_master_arbiter_if and the DUT.
module tb_bus_master_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_master_arbiter_if bus_if ();

  bus_master_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if)
  );

  // Stimulus state, indexed by master number.
  logic [3:0]  req_n;
  logic [29:0] addr  [4];
  logic        as_n  [4];
  logic        rw    [4];
  logic [31:0] wdat  [4];

  assign bus_if.m0_req_ = req_n[0];
  assign bus_if.m1_req_ = req_n[1];
  assign bus_if.m2_req_ = req_n[2];
  assign bus_if.m3_req_ = req_n[3];
  assign bus_if.m0_addr = addr[0];
  assign bus_if.m1_addr = addr[1];
  assign bus_if.m2_addr = addr[2];
  assign bus_if.m3_addr = addr[3];
  assign bus_if.m0_as_  = as_n[0];
  assign bus_if.m1_as_  = as_n[1];
  assign bus_if.m2_as_  = as_n[2];
  assign bus_if.m3_as_  = as_n[3];
  assign bus_if.m0_rw   = rw[0];
  assign bus_if.m1_rw   = rw[1];
  assign bus_if.m2_rw   = rw[2];
  assign bus_if.m3_rw   = rw[3];
  assign bus_if.m0_wr_data = wdat[0];
  assign bus_if.m1_wr_data = wdat[1];
  assign bus_if.m2_wr_data = wdat[2];
  assign bus_if.m3_wr_data = wdat[3];

  logic [3:0] gnt;
  assign gnt = {bus_if.m3_grnt_, bus_if.m2_grnt_, bus_if.m1_grnt_, bus_if.m0_grnt_};

  int checks = 0;
  int errors = 0;
  int mo = 0;   // model owner

  function automatic logic [3:0] gvec(input int i);
    logic [3:0] one;
    one = 4'b0001 << i;
    return ~one;
  endfunction

  function automatic int gnt_idx(input logic [3:0] g);
    int r;
    r = -1;
    for (int i = 0; i < 4; i++) if (g[i] === 1'b0) r = i;
    return r;
  endfunction

  // Rules: owner keeps bus while requesting; otherwise pick per selection
  // order among requesters; with nobody requesting, stay parked.
  function automatic int next_owner(input int cur, input logic [3:0] rn);
    if (!rn[cur]) return cur;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    for (int k = 1; k <= 4; k++) if (!rn[(cur + k) % 4]) return (cur + k) % 4;
`else
    for (int i = 0; i < 4; i++) if (!rn[i]) return i;
`endif
    return cur;
  endfunction

  task automatic randomize_data();
    for (int i = 0; i < 4; i++) begin
      addr[i] = 30'($urandom);
      as_n[i] = 1'($urandom);
      rw[i]   = 1'($urandom);
      wdat[i] = $urandom;
    end
  endtask

  task automatic check(input string tag);
    logic [3:0]  eg;
    logic [33:0] obs_ctl, exp_ctl;
    eg = gvec(mo);
    obs_ctl = {bus_if.s_as_, bus_if.s_rw, bus_if.s_wr_data};
    exp_ctl = {as_n[mo], rw[mo], wdat[mo]};
    checks++;
    assert (gnt === eg) else begin
      errors++; $error("FAIL %s grant obs=%b exp=%b", tag, gnt, eg);
    end
    checks++;
    assert (bus_if.s_addr === addr[mo]) else begin
      errors++; $error("FAIL %s s_addr obs=%h exp=%h", tag, bus_if.s_addr, addr[mo]);
    end
    checks++;
    assert (obs_ctl === exp_ctl) else begin
      errors++; $error("FAIL %s s_as_/rw/data obs=%h exp=%h", tag, obs_ctl, exp_ctl);
    end
    checks++;
    assert (dut.owner_q === 2'(mo)) else begin
      errors++; $error("FAIL %s owner obs=%0d exp=%0d", tag, dut.owner_q, mo);
    end
  endtask

  // One clock: model samples inputs at the edge, outputs checked 1 time unit later.
  task automatic step(input string tag);
    @(posedge clk);
    if (reset) mo = 0;
    else       mo = next_owner(mo, req_n);
    #1;
    check(tag);
  endtask

  task automatic expect_grant(input string tag, input int who);
    checks++;
    assert (gnt === gvec(who)) else begin
      errors++; $error("FAIL %s grant obs=%b exp=%b", tag, gnt, gvec(who));
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    mo = 0;
    step("reset_hold");
    reset = 1'b0;
  endtask

  initial begin
    int first, second, cnt, prev, cur, n3;
    int order[$];
    int exp_ord[5];
    reset = 1'b1;
    req_n = 4'hF;
    randomize_data();
    #2;
    check("reset_state");
    expect_grant("reset_gvec", 0);
    step("reset_hold");
    reset = 1'b0;

    // Idle bus parks on m0 and tracks its inputs.
    for (int c = 0; c < 10; c++) begin
      randomize_data();
      step("idle");
      expect_grant("idle_gvec", 0);
    end

    // m2 requests with bus free: granted after one edge, holds for 5 cycles.
    req_n = 4'b1011;
    step("m2_req");
    expect_grant("m2_latency", 2);
    for (int c = 0; c < 5; c++) begin
      randomize_data();
      step("m2_hold");
      expect_grant("m2_hold_gvec", 2);
    end

    // Owner 2 releases; bus parks on m2.
    req_n = 4'hF;
    step("m2_park");
    expect_grant("m2_park_gvec", 2);

    // m1 and m3 together while owner 2 is idle.
`ifdef BUS_ARB_ROUND_ROBIN_EN
    first = 3; second = 1;
`else
    first = 1; second = 3;
`endif
    req_n = 4'b0101;
    step("m1m3_req");
    expect_grant("m1m3_first", first);
    step("m1m3_hold");
    expect_grant("m1m3_hold", first);
    req_n[first] = 1'b1;
    step("m1m3_handover");
    expect_grant("m1m3_second", second);
    req_n = 4'hF;

    // All four request; each owner drops req_ for one cycle after 3 granted cycles.
    do_reset();
    req_n = 4'h0;
    prev = -1; cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step("all4");
      cur = gnt_idx(gnt);
      if (cur == prev) cnt++;
      else begin cnt = 1; order.push_back(cur); end
      prev = cur;
      req_n = 4'h0;
      if (cnt == 3 && cur >= 0) req_n[cur] = 1'b1;
    end
    req_n = 4'hF;
`ifdef BUS_ARB_ROUND_ROBIN_EN
    exp_ord = '{0, 1, 2, 3, 0};
`else
    exp_ord = '{0, 1, 0, 1, 0};
`endif
    checks++;
    assert (order.size() >= 5) else begin
      errors++; $error("FAIL all4_len obs=%0d exp>=5", order.size());
    end
    for (int i = 0; i < 5 && i < order.size(); i++) begin
      checks++;
      assert (order[i] === exp_ord[i]) else begin
        errors++; $error("FAIL all4_order[%0d] obs=%0d exp=%0d", i, order[i], exp_ord[i]);
      end
    end
`ifndef BUS_ARB_ROUND_ROBIN_EN
    n3 = 0;
    foreach (order[i]) if (order[i] == 3) n3++;
    checks++;
    assert (n3 === 0) else begin
      errors++; $error("FAIL all4_m3_starved obs=%0d grants exp=0", n3);
    end
`endif

    // Owner 3 holding; a one-cycle asynchronous reset pulse takes the bus to m0.
    req_n = 4'b0111;
    step("m3_req");
    expect_grant("m3_owner", 3);
    #2;
    reset = 1'b1;
    #1;
    mo = 0;
    check("async_reset");
    expect_grant("async_reset_gvec", 0);
    step("reset_pulse");
    reset = 1'b0;
    step("m3_regrant");
    expect_grant("m3_regrant_gvec", 3);

    // Owner m1 drops req_ one cycle while m2 requests: m2 takes over, m1 waits.
    req_n = 4'b1101;
    step("m1_req");
    expect_grant("m1_owner", 1);
    req_n = 4'b1001;
    step("m1_hold");
    expect_grant("m1_hold_gvec", 1);
    req_n = 4'b1011;
    step("m1_release");
    expect_grant("m2_takeover", 2);
    req_n = 4'b1001;
    step("m1_wait");
    expect_grant("m1_waits", 2);
    req_n = 4'hF;

    // Randomized traffic with occasional asynchronous reset pulses.
    for (int c = 0; c < 600; c++) begin
      randomize_data();
      if ($urandom_range(0, 2) == 0) req_n = 4'($urandom);
      if ($urandom_range(0, 49) == 0) begin
        reset = 1'b1;
        #1;
        mo = 0;
        check("rand_async_reset");
        step("rand_reset_hold");
        reset = 1'b0;
      end else begin
        step("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
